// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use and MDU stalls,
// branch/imem flushes and a perf counter of front-end stall cycles.
module hazard_ctrl #(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             reg_writeM,
    input  logic             reg_writeW,
    input  logic             loadE,
    input  logic             mdu_opE,
    input  logic             pc_srcE,
    input  logic             imem_ready,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             bubbleM,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned CW = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               mdu_stall;
    logic               lw;
    logic               stall_d_int;

    // M result is younger than W, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // MDU sequencer: the op stays in E for MDU_LAT cycles, stalling all but the last.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdu_opE) begin
                    state_d   = BUSY;
                    cnt_d     = CW'(MDU_LAT - 2);
                    mdu_stall = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d     = cnt_q - CW'(1);
                    mdu_stall = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Hazard outputs; reset forces a quiet, flushing pipeline.
    always_comb begin
        lw          = 1'b0;
        stall_d_int = 1'b0;
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        bubbleM     = 1'b0;
        flushD      = 1'b1;
        flushE      = 1'b1;
        forwardAE   = 2'b00;
        forwardBE   = 2'b00;
        if (rst) begin
            lw = loadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D))
                 && (state_q == IDLE);
            stall_d_int = lw || mdu_stall;
            // A taken branch overrides an imem wait so the PC takes the target.
            stallF    = stall_d_int || (!imem_ready && !pc_srcE);
            stallD    = stall_d_int;
            stallE    = mdu_stall;
            bubbleM   = mdu_stall;
            flushD    = pc_srcE || (!imem_ready && !stall_d_int);
            flushE    = pc_srcE || lw;
            forwardAE = fwd_sel(rs1E, rdM, reg_writeM, rdW, reg_writeW);
            forwardBE = fwd_sel(rs2E, rdM, reg_writeM, rdW, reg_writeW);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stallF);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mdu_busy  = (state_q == BUSY);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (MDU_LAT 4/CNT_W 32 and
// MDU_LAT 2/CNT_W 4) checked against a cycle-age reference model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       reg_writeM, reg_writeW, loadE, mdu_opE, pc_srcE, imem_ready;

    logic        sF_a, sD_a, sE_a, fD_a, fE_a, bM_a, busy_a;
    logic [1:0]  fA_a, fB_a;
    logic [31:0] cnt_a;
    logic        sF_b, sD_b, sE_b, fD_b, fE_b, bM_b, busy_b;
    logic [1:0]  fA_b, fB_b;
    logic [3:0]  cnt_b;

    hazard_ctrl #(.MDU_LAT(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
        .loadE(loadE), .mdu_opE(mdu_opE), .pc_srcE(pc_srcE), .imem_ready(imem_ready),
        .stallF(sF_a), .stallD(sD_a), .stallE(sE_a), .flushD(fD_a), .flushE(fE_a),
        .bubbleM(bM_a), .forwardAE(fA_a), .forwardBE(fB_a), .mdu_busy(busy_a),
        .stall_cnt(cnt_a)
    );

    hazard_ctrl #(.MDU_LAT(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
        .loadE(loadE), .mdu_opE(mdu_opE), .pc_srcE(pc_srcE), .imem_ready(imem_ready),
        .stallF(sF_b), .stallD(sD_b), .stallE(sE_b), .flushD(fD_b), .flushE(fE_b),
        .bubbleM(bM_b), .forwardAE(fA_b), .forwardBE(fB_b), .mdu_busy(busy_b),
        .stall_cnt(cnt_b)
    );

    typedef struct {
        logic        sF, sD, sE, fD, fE, bM, busy;
        logic [1:0]  fA, fB;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
    } exp2_t;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       rwM, rwW, load, mdu, pc, imem;
    } stim_t;

    exp2_t       sb[$];
    stim_t       s;
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned m_age[2];
    logic [31:0] m_cnt[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (reg_writeM && rdM != 5'd0 && rdM == rs) return 2'b10;
        if (reg_writeW && rdW != 5'd0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Reference: track how many cycles the current MDU op has spent in E.
    task automatic model_step(input int idx, input int unsigned lat, output exp_t e);
        logic busy, ms, lw;
        e = '{default: '0};
        if (!rst) begin
            e.fD = 1'b1;
            e.fE = 1'b1;
            m_age[idx] = 0;
            m_cnt[idx] = '0;
        end else begin
            busy   = (m_age[idx] != 0);
            ms     = (mdu_opE || busy) && (m_age[idx] + 1 < lat);
            lw     = loadE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D) && !busy;
            e.sF   = lw || ms || (!imem_ready && !pc_srcE);
            e.sD   = lw || ms;
            e.sE   = ms;
            e.bM   = ms;
            e.fD   = pc_srcE || (!imem_ready && !(lw || ms));
            e.fE   = pc_srcE || lw;
            e.fA   = fwd(rs1E);
            e.fB   = fwd(rs2E);
            e.busy = busy;
            e.cnt  = m_cnt[idx];
            if (busy || mdu_opE) m_age[idx] = (m_age[idx] + 1 >= lat) ? 0 : m_age[idx] + 1;
            if (e.sF) m_cnt[idx] = (idx == 1) ? ((m_cnt[idx] + 1) & 32'hF) : m_cnt[idx] + 1;
        end
    endtask

    // Apply the staged stimulus just after the edge and queue its expected response.
    task automatic step();
        exp2_t e;
        @(posedge clk);
        #1;
        rst = s.rst; rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
        rdE = s.rdE; rdM = s.rdM; rdW = s.rdW; reg_writeM = s.rwM; reg_writeW = s.rwW;
        loadE = s.load; mdu_opE = s.mdu; pc_srcE = s.pc; imem_ready = s.imem;
        model_step(0, 4, e.a);
        model_step(1, 2, e.b);
        sb.push_back(e);
        #2;
    endtask

    function automatic stim_t idle_stim();
        stim_t t;
        t = '0;
        t.rst  = 1'b1;
        t.imem = 1'b1;
        return t;
    endfunction

    // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
    always @(negedge clk) begin
        exp2_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("a.stallF", 32'(sF_a), 32'(e.a.sF));
            chk("a.stallD", 32'(sD_a), 32'(e.a.sD));
            chk("a.stallE", 32'(sE_a), 32'(e.a.sE));
            chk("a.flushD", 32'(fD_a), 32'(e.a.fD));
            chk("a.flushE", 32'(fE_a), 32'(e.a.fE));
            chk("a.bubbleM", 32'(bM_a), 32'(e.a.bM));
            chk("a.fwdA", 32'(fA_a), 32'(e.a.fA));
            chk("a.fwdB", 32'(fB_a), 32'(e.a.fB));
            chk("a.busy", 32'(busy_a), 32'(e.a.busy));
            chk("a.cnt", cnt_a, e.a.cnt);
            chk("b.stallF", 32'(sF_b), 32'(e.b.sF));
            chk("b.stallD", 32'(sD_b), 32'(e.b.sD));
            chk("b.stallE", 32'(sE_b), 32'(e.b.sE));
            chk("b.flushD", 32'(fD_b), 32'(e.b.fD));
            chk("b.flushE", 32'(fE_b), 32'(e.b.fE));
            chk("b.bubbleM", 32'(bM_b), 32'(e.b.bM));
            chk("b.fwdA", 32'(fA_b), 32'(e.b.fA));
            chk("b.fwdB", 32'(fB_b), 32'(e.b.fB));
            chk("b.busy", 32'(busy_b), 32'(e.b.busy));
            chk("b.cnt", 32'(cnt_b), e.b.cnt);
        end
    end

    initial begin
        logic [31:0] base;
        int          kind;
        rst = 1'b0; rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
        reg_writeM = 1'b0; reg_writeW = 1'b0; loadE = 1'b0; mdu_opE = 1'b0;
        pc_srcE = 1'b0; imem_ready = 1'b1;
        m_age[0] = 0; m_age[1] = 0; m_cnt[0] = '0; m_cnt[1] = '0;

        s = idle_stim();
        s.rst = 1'b0;
        repeat (3) step();
        chk("reset.flushE", 32'(fE_a), 32'd1);
        chk("reset.cnt", cnt_a, 32'd0);

        // Forwarding priority
        s = idle_stim();
        s.rs1E = 5'd5; s.rdM = 5'd5; s.rwM = 1'b1; s.rdW = 5'd5; s.rwW = 1'b1;
        step(); chk("fwd.M", 32'(fA_a), 32'd2);
        s.rwM = 1'b0;
        step(); chk("fwd.W", 32'(fA_a), 32'd1);
        s.rdM = 5'd0; s.rdW = 5'd0;
        step(); chk("fwd.x0", 32'(fA_a), 32'd0);

        // Load-use
        s = idle_stim();
        s.load = 1'b1; s.rdE = 5'd7; s.rs2D = 5'd7;
        step();
        chk("lu.stallF", 32'(sF_a), 32'd1);
        chk("lu.stallD", 32'(sD_a), 32'd1);
        chk("lu.flushE", 32'(fE_a), 32'd1);
        chk("lu.flushD", 32'(fD_a), 32'd0);
        s.rdE = 5'd0; s.rs2D = 5'd0;
        step(); chk("lu.x0", 32'(sF_a), 32'd0);

        // MDU op held in E for MDU_LAT=4
        s = idle_stim();
        base = m_cnt[0];
        s.mdu = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("mdu.stallF", 32'(sF_a), (k <= 3) ? 32'd1 : 32'd0);
            chk("mdu.busy", 32'(busy_a), (k >= 2) ? 32'd1 : 32'd0);
        end
        s.mdu = 1'b0;
        step();
        chk("mdu.idle", 32'(busy_a), 32'd0);
        chk("mdu.cnt", cnt_a, base + 32'd3);

        // Branch during imem wait
        s = idle_stim();
        s.imem = 1'b0; s.pc = 1'b1;
        step();
        chk("br.stallF", 32'(sF_a), 32'd0);
        chk("br.flushD", 32'(fD_a), 32'd1);
        chk("br.flushE", 32'(fE_a), 32'd1);
        s.pc = 1'b0;
        step();
        chk("wait.stallF", 32'(sF_a), 32'd1);
        chk("wait.flushD", 32'(fD_a), 32'd1);

        // Reset in the middle of an MDU op
        s = idle_stim();
        s.mdu = 1'b1;
        step();
        s.rst = 1'b0;
        step();
        chk("rmdu.busy", 32'(busy_a), 32'd0);
        chk("rmdu.stallF", 32'(sF_a), 32'd0);
        chk("rmdu.stallE", 32'(sE_a), 32'd0);
        chk("rmdu.flushD", 32'(fD_a), 32'd1);
        chk("rmdu.cnt", cnt_a, 32'd0);
        s = idle_stim();
        step();
        chk("rmdu.idle", 32'(busy_a), 32'd0);
        chk("rmdu.nostall", 32'(sF_a), 32'd0);

        // Counter wrap on the 4-bit instance
        s = idle_stim();
        s.rst = 1'b0;
        step();
        s.rst = 1'b1; s.imem = 1'b0;
        repeat (17) step();
        s.imem = 1'b1;
        step();
        chk("wrap.b", 32'(cnt_b), 32'd1);
        chk("wrap.a", cnt_a, 32'd17);

        // Randomized traffic, keeping E-stage controls mutually exclusive
        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(0, 79) != 0);
            s.rs1D = 5'($urandom_range(0, 3)); s.rs2D = 5'($urandom_range(0, 3));
            s.rs1E = 5'($urandom_range(0, 3)); s.rs2E = 5'($urandom_range(0, 3));
            s.rdE  = 5'($urandom_range(0, 3)); s.rdM  = 5'($urandom_range(0, 3));
            s.rdW  = 5'($urandom_range(0, 3));
            s.rwM  = 1'($urandom_range(0, 1)); s.rwW = 1'($urandom_range(0, 1));
            s.imem = ($urandom_range(0, 3) != 0);
            s.load = 1'b0; s.mdu = 1'b0; s.pc = 1'b0;
            if (m_age[0] != 0 || m_age[1] != 0) begin
                s.mdu = 1'b1;
            end else begin
                kind = int'($urandom_range(0, 6));
                if (kind == 0) s.mdu = 1'b1;
                else if (kind == 1 || kind == 2) s.load = 1'b1;
                else if (kind == 3) s.pc = 1'b1;
            end
            step();
        end

        s = idle_stim();
        step();
        @(negedge clk);
        #1;
        chk("sb.drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
